// File: rtl/add_ctrl_pkg.sv
// Shared types and helpers for the serial add sequencing controller.
package add_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef logic req_id_t;

  function automatic int calc_nslice(input int width, input int slice);
    return width / slice;
  endfunction

endpackage

// File: rtl/add_slice.sv
// Combinational SLICE-bit adder with carry-in and carry-out.
module add_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};

endmodule

// File: rtl/add_seq_ctrl.sv
// Two-requester serial adder: one shared SLICE-bit adder walks WIDTH-bit operands LSB slice first.
// Optional signed-overflow output enabled by defining ADD_SEQ_CTRL_OVF_EN.
module add_seq_ctrl
  import add_ctrl_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             busy
`ifdef ADD_SEQ_CTRL_OVF_EN
  ,
  output logic             rsp_ovf
`endif
);

  localparam int NSLICE = calc_nslice(WIDTH, SLICE);
  localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST_SLICE = CW'(NSLICE - 1);

  if ((WIDTH % SLICE) != 0 || NSLICE < 1) begin : g_bad_width
    $fatal(1, "add_seq_ctrl: WIDTH must be a positive multiple of SLICE");
  end

  state_e           state_q, state_d;
  req_id_t          prio_q, prio_d;
  req_id_t          id_q, id_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             rsp_valid_q, rsp_valid_d;
  req_id_t          rsp_id_q, rsp_id_d;
  logic             rsp_cout_q, rsp_cout_d;
  logic             busy_q, busy_d;

  logic             gnt0, gnt1, last_slice;
  int               slice_base;
  logic [SLICE-1:0] slice_a, slice_b, slice_sum;
  logic             slice_cout;

  // prio_q names the requester that wins a tie; it flips to the other one on every grant
  assign gnt0 = req0_valid && (!req1_valid || prio_q == 1'b0);
  assign gnt1 = req1_valid && (!req0_valid || prio_q == 1'b1);
  assign req0_ready = !rst && (state_q == IDLE) && gnt0;
  assign req1_ready = !rst && (state_q == IDLE) && gnt1;

  assign slice_base = int'(cnt_q) * SLICE;
  assign slice_a    = a_q[slice_base +: SLICE];
  assign slice_b    = b_q[slice_base +: SLICE];
  assign last_slice = (state_q == RUN) && (cnt_q == LAST_SLICE);

  add_slice #(.SLICE(SLICE)) u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    id_d        = id_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_cout_d  = rsp_cout_q;
    case (state_q)
      IDLE: begin
        if (req0_ready || req1_ready) begin
          a_d     = req1_ready ? req1_a : req0_a;
          b_d     = req1_ready ? req1_b : req0_b;
          carry_d = req1_ready ? req1_cin : req0_cin;
          id_d    = req1_ready;
          prio_d  = !req1_ready;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[slice_base +: SLICE] = slice_sum;
        carry_d = slice_cout;
        cnt_d   = cnt_q + 1'b1;
        if (last_slice) begin
          state_d     = DONE;
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          rsp_cout_d  = slice_cout;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      id_q        <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_cout_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      id_q        <= id_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_cout_q  <= rsp_cout_d;
      busy_q      <= busy_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = sum_q;
  assign rsp_cout  = rsp_cout_q;
  assign busy      = busy_q;

`ifdef ADD_SEQ_CTRL_OVF_EN
  logic ovf_q, ovf_d;

  // The top slice's sum MSB is the result sign, so overflow is decided on the last slice
  always_comb begin
    ovf_d = ovf_q;
    if (last_slice)
      ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_sum[SLICE-1] != a_q[WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign rsp_ovf = ovf_q;
`endif

endmodule

// File: doc/add_seq_ctrl.md
# add_seq_ctrl

Sequencing controller that shares one narrow SLICE-bit adder (same cin/cout form as the ADD_n_n cells) between two requesters. It performs WIDTH-bit additions serially, least-significant slice first, over WIDTH/SLICE cycles, with the carry held in a register between slices. It sits between two operand producers and a single result consumer, and gives area-constrained datapaths wide adds without instantiating a full-width adder.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of SLICE.
- SLICE, 4, adder slice width; NSLICE = WIDTH/SLICE, NSLICE >= 1.

- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 is accepted this cycle.
- req0_a, req0_b  in  WIDTH  operands, requester 0.
- req0_cin  in  1  carry-in, requester 0.
- req1_valid, req1_ready, req1_a, req1_b, req1_cin: same as the requester 0 ports, for requester 1.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  1  index of the requester that owns the result.
- rsp_sum  out  WIDTH  a + b + cin, modulo 2^WIDTH.
- rsp_cout  out  1  carry out of the MSB.
- busy  out  1  high whenever state != IDLE.
- rsp_ovf  out  1  two's-complement overflow; present only with the macro (see Configuration).

## Operation
- Reset:
  - state = IDLE; round-robin pointer favours req0.
  - Outputs: req*_ready = 0, rsp_valid = 0, rsp_id = 0, rsp_sum = 0, rsp_cout = 0, busy = 0, rsp_ovf = 0.
  - Slice counter and carry register cleared.
- States:
  - IDLE -> RUN when any req*_valid is high.
  - RUN -> DONE after slice NSLICE-1.
  - DONE -> IDLE on rsp_ready.
- Arbitration (IDLE only):
  - A single requester valid is granted.
  - With both valid, the requester not granted last wins; the pointer updates on every grant.
  - req*_ready is combinational: (state == IDLE) && grant. Transfer = valid && ready.
- On transfer:
  - Latch a, b and id.
  - Carry register <= cin; slice counter <= 0.
- RUN, slice k:
  - Add a[k*SLICE +: SLICE] + b[same slice] + carry register.
  - Write the sum slice into the result register; carry register <= slice cout; k increments.
- After the last slice:
  - rsp_cout = final carry.
  - rsp_sum, rsp_id and rsp_cout are held stable while rsp_valid && !rsp_ready.
- Requester valid or operand changes are ignored outside IDLE. Requesters must hold operands only until the transfer.
- Reset in any state aborts the operation: no response and no ready is produced, and the pointer returns to req0.

## Timing
- Accept at edge T.
- RUN occupies NSLICE cycles.
- rsp_valid is first high in the cycle after edge T+NSLICE, i.e. NSLICE+1 cycles after the accept cycle.
- rsp_valid stays high until the edge where rsp_ready = 1. It then falls, and the state is IDLE in the next cycle.
- The earliest next accept is the cycle after the response handshake, giving a throughput of one operation per NSLICE+2 cycles with no backpressure.
- NSLICE = 1 is legal: one RUN cycle.
- All outputs are registered except req*_ready.

## Configuration
- Macro ADD_SEQ_CTRL_OVF_EN.
- With the macro defined:
  - Port rsp_ovf exists.
  - On the last slice, rsp_ovf <= (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]).
  - rsp_ovf is held with the other response fields and reset to 0.
- Without the macro: no rsp_ovf port and no related logic. All other behaviour is identical.

## Structure
- Shared package add_ctrl_pkg:
  - state enum {IDLE, RUN, DONE}.
  - Requester-id type.
  - Function to compute NSLICE.
- Sub-module add_slice: combinational SLICE-bit adder with a, b, cin, sum and cout, instantiated once.
- The top level holds the FSM, arbiter, operand/result registers, slice counter and carry register.
- Elaboration check fails if WIDTH % SLICE != 0.

## Test plan
- Defaults; req0 a = 0x1234, b = 0x0FF0, cin = 0 -> rsp_sum = 0x2224, rsp_cout = 0, rsp_id = 0, rsp_valid 5 cycles after the accept cycle.
- Cross-slice carries:
  - 0xFFFF + 0x0001, cin = 0 -> sum 0x0000, cout 1.
  - 0xFFFF + 0x0000, cin = 1 -> sum 0x0000, cout 1.
- Both requesters continuously valid, rsp_ready = 1 -> grants alternate 0, 1, 0, 1; each op spaced 6 cycles apart.
- rsp_ready low for 3 cycles in DONE -> response fields stable, both req*_ready = 0, busy = 1; accept resumes the cycle after the handshake.
- rst pulsed in the 2nd RUN cycle -> no rsp_valid ever; next cycle busy = 0. Then both requesters valid -> req0 granted.
- With ADD_SEQ_CTRL_OVF_EN:
  - 0x7FFF + 0x0001 -> sum 0x8000, ovf 1, cout 0.
  - 0x8000 + 0xFFFF -> sum 0x7FFF, ovf 1, cout 1.
  - 0x0003 + 0x0004 -> ovf 0.
